// File: rtl/spi_reg_bank_if.sv
// rtl/spi_reg_bank_if.sv - SPI pin bundle between an external host and the register bank.
interface spi_reg_bank_if;
    logic sck;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sck,
        output cs,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sck,
        input  cs,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode 0 slave register bank with burst read/write, RO masking and write strobes.
module spi_reg_bank #(
    parameter int                     NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = 8'h80,
    parameter logic [NUM_REGS*8-1:0]  RESET_VALS = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_reg_bank_if.slave           spi,
    input  logic [NUM_REGS*8-1:0]   ro_in,
    output logic [NUM_REGS*8-1:0]   reg_q,
    output logic [NUM_REGS-1:0]     wr_strobe,
    output logic                    busy
);
    localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, IGN} state_t;

    state_t          state;
    logic [2:0]      sck_s;
    logic [1:0]      cs_s;
    logic [1:0]      mosi_s;
    logic [1:0]      settle;
    logic            armed;
    logic [2:0]      bit_cnt;
    logic [6:0]      rx_sr;
    logic [7:0]      tx_sr;
    logic [PW-1:0]   ptr;
    logic            miso_oe;
    logic [7:0]      regs [NUM_REGS];

    logic            sck_rise;
    logic            sck_fall;
    logic            byte_done;
    logic [7:0]      rx_byte;
    logic            addr_ok;
    logic [PW-1:0]   rd_idx;
    logic [PW-1:0]   ptr_inc;
    logic [7:0]      rd_val;

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign rx_byte   = {rx_sr, mosi_s[1]};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign addr_ok   = ({25'd0, rx_byte[6:0]} < NUM_REGS);

    // During the command byte the read target is the address being received, afterwards the pointer.
    always_comb begin
        rd_idx  = (state == CMD) ? rx_byte[PW-1:0] : ptr;
        ptr_inc = (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
        rd_val  = RO_MASK[rd_idx] ? ro_in[{rd_idx, 3'b000} +: 8] : regs[rd_idx];
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*8 +: 8] = RO_MASK[i] ? ro_in[i*8 +: 8] : regs[i];
    end

    assign busy        = ~cs_s[1];
    assign spi.miso_oe = miso_oe;
    assign spi.miso    = miso_oe & tx_sr[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s     <= 3'b000;
            cs_s      <= 2'b11;
            mosi_s    <= 2'b00;
            settle    <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            ptr       <= '0;
            miso_oe   <= 1'b0;
            wr_strobe <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALS[i*8 +: 8];
            end
        end else begin
            sck_s     <= {sck_s[1:0], spi.sck};
            cs_s      <= {cs_s[0], spi.cs};
            mosi_s    <= {mosi_s[0], spi.mosi};
            settle    <= {settle[0], 1'b1};
            wr_strobe <= '0;
            // Only arm once the synchroniser holds real pin samples, so a frame cut by reset stays ignored.
            if (settle[1] && cs_s[1]) begin
                armed <= 1'b1;
            end
            if (cs_s[1]) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                miso_oe <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state   <= CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (byte_done) begin
                            if (!addr_ok) begin
                                state <= IGN;
                            end else if (rx_byte[7]) begin
                                state   <= RD;
                                miso_oe <= 1'b1;
                                tx_sr   <= rd_val;
                                ptr     <= ptr_inc;
                            end else begin
                                state <= WR;
                                ptr   <= rx_byte[PW-1:0];
                            end
                        end
                    end
                    WR: begin
                        if (byte_done) begin
                            if (!RO_MASK[ptr]) begin
                                regs[ptr]      <= rx_byte;
                                wr_strobe[ptr] <= 1'b1;
                            end
                            ptr <= ptr_inc;
                        end
                    end
                    RD: begin
                        if (byte_done) begin
                            tx_sr <= rd_val;
                            ptr   <= ptr_inc;
                        end else if (sck_fall && (bit_cnt != 3'd0)) begin
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    IGN: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI Mode 0 (CPOL=0, CPHA=0) slave register bank, successor to the fixed 7-register write-only SPI receiver. Provides a configurable number of 8-bit registers, a command byte with read/write select, burst auto-increment with wrap, per-register read-only masking, readback over MISO, and per-register write strobes. Sits between the external SPI host pins and the synth core's control/frequency/duty/volume/status registers.

## Interface
- NUM_REGS, 8 — number of 8-bit registers (1..128)
- RO_MASK, 8'h80 — bit i set: register i is read-only (value sourced from ro_in)
- RESET_VALS, {NUM_REGS*8{1'b0}} — flattened reset value of each writable register (register i at bits 8i+7:8i)

- clk  input  1  system clock, must be ≥8× SCK frequency
- rst  input  1  synchronous, active-high reset
- spi_sck  input  1  SPI clock, asynchronous to clk
- spi_cs  input  1  chip select, active low, asynchronous
- spi_mosi  input  1  host-to-slave data, asynchronous
- spi_miso  output  1  slave-to-host data
- spi_miso_oe  output  1  MISO output enable
- ro_in  input  NUM_REGS*8  live values for read-only registers
- reg_q  output  NUM_REGS*8  register contents; RO slices pass ro_in straight through
- wr_strobe  output  NUM_REGS  one-cycle pulse per committed write, bit = register index
- busy  output  1  high while a transaction is in progress (synchronised CS low)

## Operation
- sck, cs, mosi each pass through a 2-FF synchroniser; a third SCK stage provides rise/fall detection. All logic runs on clk only.
- Frame: cs falls → command byte, MSB first. Bit 7 = R (1 = read, 0 = write), bits 6:0 = start address. Then any number of data bytes.
- bit_cnt counts detected rising edges within a byte (0..7); mosi is sampled on each rise; on the 8th rise the byte completes and bit_cnt returns to 0.
- FSM states:
  - IDLE: cs high.
  - CMD: cs low, command byte in progress.
  - WR: write data bytes.
  - RD: read data bytes.
  - IGN: start address ≥ NUM_REGS.
- Transitions: IDLE→CMD on cs low. At CMD byte complete: →IGN if addr ≥ NUM_REGS; otherwise →RD if R=1, else →WR. Any state→IDLE on cs high.
- WR: on each completed byte, if RO_MASK[ptr]=0, write reg[ptr] and pulse wr_strobe[ptr]. Read-only targets are dropped silently, with no strobe. ptr then increments.
- RD: tx_sr is loaded with the value of reg[ptr] (ro_in slice if read-only) when the command byte completes and when each data byte completes; ptr increments after each such load. spi_miso = tx_sr[7]. tx_sr shifts left on each detected falling edge with bit_cnt ≠ 0, so the falling edge that immediately follows a load does not shift.
- Pointer wrap: ptr = NUM_REGS-1 increments to 0.
- IGN: no writes, no strobes, spi_miso = 0, until cs rises.
- cs rising mid-byte: the partial byte is discarded with no write; the FSM goes to IDLE and bit_cnt is cleared.
- spi_miso_oe = 1 only in RD; spi_miso = 0 whenever spi_miso_oe = 0.

## Timing
- Reset values:
  - writable slices of reg_q = RESET_VALS
  - wr_strobe = 0, busy = 0, spi_miso = 0, spi_miso_oe = 0
  - FSM = IDLE, bit_cnt = 0, ptr = 0, synchronisers cleared to idle levels (cs = 1, sck = 0)
- Reset asserted mid-transaction aborts the frame. After reset is released, the bank ignores bus activity until cs has been seen high.
- Edge detect latency: a detected edge is flagged 3 clk cycles after the raw pin edge.
- Write latency: reg_q updates and wr_strobe pulses in the cycle after the 8th rise is flagged, i.e. ≤4 clk after the raw SCK edge.
- MISO: valid ≤4 clk after the raw falling edge (or after the load). This meets Mode 0 setup for SCK ≤ clk/8.
- busy follows synchronised cs, with 2 clk latency.
- Same-cycle SPI write and ro_in change to the same register: ro_in wins, because the register is read-only and the write is dropped.

## Test plan
- After rst, reg_q = RESET_VALS, outputs 0. Write frame [0x00][0x1D] → reg_q[7:0] = 0x1D; wr_strobe[0] pulses exactly once, for 1 cycle.
- Burst write [0x02][0xAA][0xBB][0xCC] → regs 2/3/4 = AA/BB/CC. Burst [0x06][0x11][0x22][0x33] with NUM_REGS = 8 → reg6 = 11, reg7 unchanged (RO), reg0 = 33 (wrap).
- Read-only register: ro_in[63:56] = 0x03, then write [0x07][0xFF] → slice still 0x03, no strobe. Read [0x87][xx] → MISO returns 0x03.
- Readback burst: [0x82][x][x][x] → MISO bytes AA, BB, CC. spi_miso_oe is high only during the data bytes.
- Invalid address with NUM_REGS = 8: [0x10][0x42] → no register changes, no strobes; read [0x90][x] → MISO = 0x00.
- Aborts:
  - cs raised after 4 bits of a data byte → no write, FSM returns to IDLE, and the next full frame works.
  - rst pulsed mid-frame → reset values restored, and the remainder of that frame is ignored.
